// File: rtl/traffic_pkg.sv
// Shared types and constants for the road-section game sequencer.
package traffic_pkg;

   localparam int unsigned SPEED_W   = 5;
   localparam int unsigned MAX_LANES = 8;
   localparam int unsigned LEVEL_W   = 4;
   localparam int unsigned LIVES_W   = 2;

   typedef logic [SPEED_W-1:0] speed_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PLAY     = 3'd1,
      HIT      = 3'd2,
      LEVEL_UP = 3'd3,
      OVER     = 3'd4
   } state_t;

   // Level-0 wait count per lane; higher levels subtract from these.
   localparam speed_t BASE_SPEED [MAX_LANES] = '{5'd4, 5'd6, 5'd3, 5'd8, 5'd5, 5'd7, 5'd2, 5'd9};

endpackage

// File: rtl/traffic_scheduler_if.sv
// Game-logic <-> scheduler signal bundle; master drives the requests, slave is the scheduler.
interface traffic_scheduler_if #(
   parameter int unsigned NUM_LANES = 4
);
   logic                                      Start;
   logic [NUM_LANES-1:0]                      Car_Collision;
   logic [10:0]                               Frog_Y;
   logic [traffic_pkg::SPEED_W*NUM_LANES-1:0] Lane_Speed;
   logic [NUM_LANES-1:0]                      Lane_Direction;
   logic                                      Car_Reset;
   logic                                      Frog_Reset;
   logic                                      Freeze;
   logic [traffic_pkg::LIVES_W-1:0]           Lives;
   logic [traffic_pkg::LEVEL_W-1:0]           Level;
   logic                                      Game_Over;

   modport master (
      output Start, Car_Collision, Frog_Y,
      input  Lane_Speed, Lane_Direction, Car_Reset, Frog_Reset, Freeze, Lives, Level, Game_Over
   );

   modport slave (
      input  Start, Car_Collision, Frog_Y,
      output Lane_Speed, Lane_Direction, Car_Reset, Frog_Reset, Freeze, Lives, Level, Game_Over
   );
endinterface

// File: rtl/lane_cfg.sv
// Registered per-lane wait count and direction derived from the current level.
module lane_cfg
   import traffic_pkg::*;
#(
   parameter speed_t MIN_SPEED = 5'd1
) (
   input  logic               frame_clk,
   input  logic               Reset,
   input  logic [LEVEL_W-1:0] Level,
   input  logic [2:0]         lane_idx,
   output speed_t             Speed,
   output logic               Direction
);
   localparam int unsigned CALC_W = 6;

   logic [CALC_W-1:0] base_w;
   logic [CALC_W-1:0] level_w;
   logic [CALC_W-1:0] floor_w;
   speed_t            speed_c;
   speed_t            reset_speed_c;
   logic              dir_c;

   // Widened subtraction so a high level clamps to the floor instead of wrapping.
   always_comb begin
      base_w        = CALC_W'(BASE_SPEED[lane_idx]);
      level_w       = CALC_W'(Level);
      floor_w       = CALC_W'(MIN_SPEED);
      speed_c       = MIN_SPEED;
      if (base_w >= level_w + floor_w) speed_c = SPEED_W'(base_w - level_w);
      reset_speed_c = (BASE_SPEED[lane_idx] >= MIN_SPEED) ? BASE_SPEED[lane_idx] : MIN_SPEED;
      dir_c         = lane_idx[0] ^ Level[0];
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         Speed     <= reset_speed_c;
         Direction <= lane_idx[0];
      end else begin
         Speed     <= speed_c;
         Direction <= dir_c;
      end
   end
endmodule

// File: rtl/traffic_scheduler.sv
// Per-frame game sequencer: lives, level, freezes and re-home pulses for cars and frog.
module traffic_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned NUM_LANES    = 4,
   parameter int unsigned HIT_FRAMES   = 60,
   parameter int unsigned LEVEL_FRAMES = 90,
   parameter int unsigned START_LIVES  = 3,
   parameter int unsigned MAX_LEVEL    = 15,
   parameter logic [10:0] GOAL_Y       = 11'd40,
   parameter speed_t      MIN_SPEED    = 5'd1
) (
   input logic                frame_clk,
   input logic                Reset,
   traffic_scheduler_if.slave bus
);
   localparam int unsigned MAX_FRAMES = (HIT_FRAMES > LEVEL_FRAMES) ? HIT_FRAMES : LEVEL_FRAMES;
   localparam int unsigned TIMER_W    = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

   state_t               state_q, state_d;
   logic [LIVES_W-1:0]   lives_q, lives_d;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 car_reset_q, car_reset_d;
   logic                 frog_reset_q, frog_reset_d;
   logic                 freeze_q;
   logic                 game_over_q;
   logic                 start_q;
   logic                 hit_c;
   logic                 goal_c;
   speed_t               lane_speed [NUM_LANES];
   logic [NUM_LANES-1:0] lane_dir;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state plus the counters and pulses that accompany each transition.
   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      level_d      = level_q;
      timer_d      = '0;
      car_reset_d  = 1'b0;
      frog_reset_d = 1'b0;
      hit_c        = |bus.Car_Collision;
      goal_c       = (bus.Frog_Y <= GOAL_Y);

      unique case (state_q)
         IDLE: begin
            if (bus.Start) begin
               state_d      = PLAY;
               lives_d      = LIVES_W'(START_LIVES);
               level_d      = '0;
               car_reset_d  = 1'b1;
               frog_reset_d = 1'b1;
            end
         end
         PLAY: begin
            if (hit_c) begin
               state_d = HIT;
               lives_d = lives_q - LIVES_W'(1);
            end else if (goal_c) begin
               state_d = LEVEL_UP;
            end
         end
         HIT: begin
            timer_d = timer_q + TIMER_W'(1);
            if (timer_q == TIMER_W'(HIT_FRAMES - 1)) begin
               timer_d = '0;
               if (lives_q == '0) begin
                  state_d = OVER;
               end else begin
                  state_d      = PLAY;
                  frog_reset_d = 1'b1;
               end
            end
         end
         LEVEL_UP: begin
            timer_d = timer_q + TIMER_W'(1);
            if (timer_q == TIMER_W'(LEVEL_FRAMES - 1)) begin
               timer_d      = '0;
               state_d      = PLAY;
               level_d      = (level_q >= LEVEL_W'(MAX_LEVEL)) ? level_q : level_q + LEVEL_W'(1);
               car_reset_d  = 1'b1;
               frog_reset_d = 1'b1;
            end
         end
         OVER: begin
            // Only a fresh press restarts; a Start held across the game-over is ignored.
            if (bus.Start && !start_q) begin
               state_d      = PLAY;
               lives_d      = LIVES_W'(START_LIVES);
               level_d      = '0;
               car_reset_d  = 1'b1;
               frog_reset_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         lives_q      <= '0;
         level_q      <= '0;
         timer_q      <= '0;
         car_reset_q  <= 1'b1;
         frog_reset_q <= 1'b1;
         freeze_q     <= 1'b1;
         game_over_q  <= 1'b0;
         start_q      <= 1'b0;
      end else begin
         lives_q      <= lives_d;
         level_q      <= level_d;
         timer_q      <= timer_d;
         car_reset_q  <= car_reset_d;
         frog_reset_q <= frog_reset_d;
         freeze_q     <= (state_d != PLAY);
         game_over_q  <= (state_d == OVER);
         start_q      <= bus.Start;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lane_cfg #(
         .MIN_SPEED (MIN_SPEED)
      ) u_lane_cfg (
         .frame_clk (frame_clk),
         .Reset     (Reset),
         .Level     (level_q),
         .lane_idx  (3'(i)),
         .Speed     (lane_speed[i]),
         .Direction (lane_dir[i])
      );
      assign bus.Lane_Speed[i*SPEED_W +: SPEED_W] = lane_speed[i];
   end

   assign bus.Lane_Direction = lane_dir;
   assign bus.Car_Reset      = car_reset_q;
   assign bus.Frog_Reset     = frog_reset_q;
   assign bus.Freeze         = freeze_q;
   assign bus.Lives          = lives_q;
   assign bus.Level          = level_q;
   assign bus.Game_Over      = game_over_q;
endmodule

// File: tb/tb_traffic_scheduler.sv
// Self-checking bench: frame-level game model compared every frame, plus directed literal checks.
module tb_traffic_scheduler;

   logic frame_clk;
   logic Reset;

   traffic_scheduler_if #(.NUM_LANES(4)) bus ();

   traffic_scheduler #(
      .NUM_LANES    (4),
      .HIT_FRAMES   (60),
      .LEVEL_FRAMES (90),
      .START_LIVES  (3),
      .MAX_LEVEL    (15),
      .GOAL_Y       (11'd40),
      .MIN_SPEED    (5'd1)
   ) dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (bus)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Frame-level game model: a running game, an optional freeze countdown and its cause.
   int base_speed [4] = '{4, 6, 3, 8};
   int m_lives, m_level, m_lane_level, m_freeze_left;
   bit m_running, m_over, m_cause_hit, m_cr, m_fr, m_start_prev;

   always @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         m_lives = 0; m_level = 0; m_lane_level = 0; m_freeze_left = 0;
         m_running = 0; m_over = 0; m_cause_hit = 0; m_cr = 1; m_fr = 1; m_start_prev = 0;
      end else begin
         m_lane_level = m_level;
         m_cr = 0;
         m_fr = 0;
         if (!m_running) begin
            if (bus.Start && (!m_over || !m_start_prev)) begin
               m_running = 1; m_over = 0; m_lives = 3; m_level = 0;
               m_freeze_left = 0; m_cr = 1; m_fr = 1;
            end
         end else if (m_freeze_left == 0) begin
            if (bus.Car_Collision != 0) begin
               m_lives = m_lives - 1; m_freeze_left = 60; m_cause_hit = 1;
            end else if (bus.Frog_Y <= 40) begin
               m_freeze_left = 90; m_cause_hit = 0;
            end
         end else begin
            m_freeze_left = m_freeze_left - 1;
            if (m_freeze_left == 0) begin
               if (m_cause_hit) begin
                  if (m_lives == 0) begin m_running = 0; m_over = 1; end
                  else m_fr = 1;
               end else begin
                  m_level = (m_level < 15) ? m_level + 1 : 15;
                  m_cr = 1; m_fr = 1;
               end
            end
         end
         m_start_prev = bus.Start;
      end
   end

   // Compare every frame, mid-cycle.
   always @(negedge frame_clk) begin
      int exp_speed;
      chk("Lives",      32'(bus.Lives),      32'(m_lives));
      chk("Level",      32'(bus.Level),      32'(m_level));
      chk("Freeze",     32'(bus.Freeze),     32'(!m_running || m_freeze_left != 0));
      chk("Game_Over",  32'(bus.Game_Over),  32'(m_over));
      chk("Car_Reset",  32'(bus.Car_Reset),  32'(m_cr));
      chk("Frog_Reset", 32'(bus.Frog_Reset), 32'(m_fr));
      for (int i = 0; i < 4; i++) begin
         exp_speed = base_speed[i] - m_lane_level;
         if (exp_speed < 1) exp_speed = 1;
         chk($sformatf("Lane_Speed%0d", i), 32'(bus.Lane_Speed[i*5 +: 5]), 32'(exp_speed));
         chk($sformatf("Lane_Direction%0d", i), 32'(bus.Lane_Direction[i]), 32'((i % 2) ^ (m_lane_level % 2)));
      end
   end

   task automatic frames(input int n);
      repeat (n) @(negedge frame_clk);
   endtask

   task automatic hit_and_wait(input logic [3:0] mask);
      bus.Car_Collision = mask;
      frames(1);
      bus.Car_Collision = '0;
      frames(60);
   endtask

   task automatic goal_and_wait();
      bus.Frog_Y = 11'd40;
      frames(1);
      bus.Frog_Y = 11'd200;
      frames(90);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1;
      bus.Start = 1'b0;
      bus.Car_Collision = '0;
      bus.Frog_Y = 11'd200;
      frames(3);
      chk("rst_lives", 32'(bus.Lives), 0);
      chk("rst_freeze", 32'(bus.Freeze), 1);
      chk("rst_car_reset", 32'(bus.Car_Reset), 1);
      chk("rst_game_over", 32'(bus.Game_Over), 0);
      Reset = 1'b0;
      frames(1);
      chk("post_rst_car_reset", 32'(bus.Car_Reset), 0);
      frames(2);

      // Start
      bus.Start = 1'b1;
      frames(1);
      bus.Start = 1'b0;
      chk("start_car_reset", 32'(bus.Car_Reset), 1);
      chk("start_frog_reset", 32'(bus.Frog_Reset), 1);
      chk("start_lives", 32'(bus.Lives), 3);
      chk("start_freeze", 32'(bus.Freeze), 0);
      chk("start_speed0", 32'(bus.Lane_Speed[4:0]), 4);
      chk("start_speed1", 32'(bus.Lane_Speed[9:5]), 6);
      chk("start_dir", 32'(bus.Lane_Direction), 32'b1010);
      chk("model_lives", 32'(m_lives), 3);
      frames(1);
      chk("start_pulse_width", 32'(bus.Car_Reset), 0);
      frames(3);

      // Hit, with a masked collision during the freeze
      bus.Car_Collision = 4'b0100;
      frames(1);
      bus.Car_Collision = '0;
      chk("hit_lives", 32'(bus.Lives), 2);
      chk("hit_freeze", 32'(bus.Freeze), 1);
      frames(10);
      bus.Car_Collision = 4'b1111;
      frames(1);
      bus.Car_Collision = '0;
      frames(48);
      chk("hit_last_frozen", 32'(bus.Freeze), 1);
      chk("hit_masked_lives", 32'(bus.Lives), 2);
      frames(1);
      chk("hit_frog_reset", 32'(bus.Frog_Reset), 1);
      chk("hit_car_reset", 32'(bus.Car_Reset), 0);
      chk("hit_resume", 32'(bus.Freeze), 0);
      frames(2);

      // Goal -> level up
      bus.Frog_Y = 11'd40;
      frames(1);
      bus.Frog_Y = 11'd200;
      chk("goal_freeze", 32'(bus.Freeze), 1);
      frames(89);
      chk("goal_level_before", 32'(bus.Level), 0);
      frames(1);
      chk("goal_level", 32'(bus.Level), 1);
      chk("goal_car_reset", 32'(bus.Car_Reset), 1);
      chk("goal_frog_reset", 32'(bus.Frog_Reset), 1);
      chk("goal_speed_lag", 32'(bus.Lane_Speed[4:0]), 4);
      frames(1);
      chk("goal_speed0", 32'(bus.Lane_Speed[4:0]), 3);
      chk("goal_dir", 32'(bus.Lane_Direction), 32'b0101);
      frames(2);

      // Hit and goal in the same frame: hit wins
      bus.Car_Collision = 4'b0001;
      bus.Frog_Y = 11'd20;
      frames(1);
      bus.Car_Collision = '0;
      bus.Frog_Y = 11'd200;
      chk("both_lives", 32'(bus.Lives), 1);
      chk("both_level", 32'(bus.Level), 1);
      frames(60);
      chk("both_resume", 32'(bus.Freeze), 0);
      frames(2);

      // Last life lost while Start is already held
      bus.Car_Collision = 4'b0010;
      frames(1);
      bus.Car_Collision = '0;
      bus.Start = 1'b1;
      chk("last_lives", 32'(bus.Lives), 0);
      frames(60);
      chk("over_flag", 32'(bus.Game_Over), 1);
      chk("over_frog_reset", 32'(bus.Frog_Reset), 0);
      frames(5);
      chk("over_held_start", 32'(bus.Game_Over), 1);
      bus.Start = 1'b0;
      frames(1);
      bus.Start = 1'b1;
      frames(1);
      bus.Start = 1'b0;
      chk("restart_lives", 32'(bus.Lives), 3);
      chk("restart_level", 32'(bus.Level), 0);
      chk("restart_car_reset", 32'(bus.Car_Reset), 1);
      chk("restart_game_over", 32'(bus.Game_Over), 0);
      frames(2);

      // Three hits from full lives
      hit_and_wait(4'b1000);
      hit_and_wait(4'b0001);
      hit_and_wait(4'b0110);
      chk("three_hits_over", 32'(bus.Game_Over), 1);
      chk("three_hits_lives", 32'(bus.Lives), 0);
      bus.Start = 1'b1;
      frames(1);
      bus.Start = 1'b0;
      chk("restart2_lives", 32'(bus.Lives), 3);
      frames(2);

      // Level saturation
      for (int k = 0; k < 16; k++) goal_and_wait();
      frames(1);
      chk("sat_level", 32'(bus.Level), 15);
      chk("sat_speed0", 32'(bus.Lane_Speed[4:0]), 1);
      chk("sat_speed_all", 32'(bus.Lane_Speed), 32'h0000_8421);
      chk("sat_dir", 32'(bus.Lane_Direction), 32'b0101);

      // Reset in the middle of a hit freeze
      bus.Car_Collision = 4'b0001;
      frames(1);
      bus.Car_Collision = '0;
      frames(20);
      #2 Reset = 1'b1;
      #1;
      chk("midrst_lives", 32'(bus.Lives), 0);
      chk("midrst_level", 32'(bus.Level), 0);
      chk("midrst_freeze", 32'(bus.Freeze), 1);
      chk("midrst_car_reset", 32'(bus.Car_Reset), 1);
      chk("midrst_game_over", 32'(bus.Game_Over), 0);
      frames(1);
      Reset = 1'b0;
      frames(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
